floo_wormhole_arbiter: RTL
==========================

// Module: floo_wormhole_arbiter
// PURPOSE
//   Round-robin, packet-atomic (wormhole) arbiter that shares one NoC link among NumInp flit sources.
//   Each source is a valid/ready flit stream with a last marker.
//   Once a source is granted, it keeps the link until its last flit handshakes.
//   Sits between local requesters (cluster NI, DMA test node, config ports) and a router input/output port of a compute tile.
// PARAMETERS
//   NumInp     4    number of requesting flit streams (>=2)
//   DataWidth  64   flit payload width in bits, forwarded unmodified
//   IdxWidth   $clog2(NumInp)  derived; width of grant index
// PORTS
//   clk_i       in   1                   clock, all state on rising edge
//   rst_i       in   1                   synchronous reset, active-high
//   valid_i     in   NumInp              per-source flit valid
//   ready_o     out  NumInp              per-source flit ready
//   data_i      in   NumInp x DataWidth  per-source flit payload
//   last_i      in   NumInp              per-source last-flit-of-packet marker
//   valid_o     out  1                   link flit valid
//   ready_i     in   1                   link flit ready
//   data_o      out  DataWidth           link flit payload (mux of granted source)
//   last_o      out  1                   link last marker
//   gnt_idx_o   out  IdxWidth            index of currently selected source
//   locked_o    out  1                   1 = grant held (state LOCKED)
// BEHAVIOUR
//   - Zero-latency path: data_o/last_o/valid_o are combinational from the selected source; ready_o[sel] = ready_i, all other ready_o = 0.
//   - State: IDLE / LOCKED (enum), plus rr_ptr (IdxWidth) and lock_idx (IdxWidth) registers.
//   - IDLE: sel = first i with valid_i[i], scanning rr_ptr, rr_ptr+1, ... modulo NumInp. valid_o = |valid_i.
//       - handshake && last_o: stay IDLE; rr_ptr <= (sel+1) mod NumInp.
//       - valid_o && !(handshake && last_o), i.e. stalled or non-last flit: LOCKED, lock_idx <= sel.
//       - Locking on a stall keeps valid_o/data_o stable when a higher-priority source raises valid later.
//   - LOCKED: sel = lock_idx; valid_o = valid_i[lock_idx]; other sources are ignored.
//       - handshake && last_o: IDLE; rr_ptr <= (lock_idx+1) mod NumInp.
//       - otherwise stay LOCKED, including bubbles where valid_i[lock_idx] = 0.
//   - gnt_idx_o = sel in both states (0 when IDLE with no valid); locked_o = (state==LOCKED).
//   - rr_ptr wrap: NumInp-1 -> 0; for non-power-of-2 NumInp, index values >= NumInp never occur.
//   - Single-flit packet (last on first flit) completes with no LOCKED cycle; back-to-back grants are possible every cycle.
//   - Simultaneous requests: the source at or after rr_ptr wins; fairness is strict rotation across packets.
//   - Reset (rst_i=1, any cycle, including mid-packet):
//       - next state IDLE, rr_ptr=0, lock_idx=0;
//       - while rst_i=1, force valid_o=0, ready_o='0, last_o=0, locked_o=0, gnt_idx_o=0, data_o='0.
//       - A packet in flight is truncated; upstream must also be reset.
//   - Sources must follow valid/ready rules: valid and data held until ready. The arbiter never drops valid_o without a handshake.
//   - Assertions: valid_o && !ready_i implies valid_o, data_o and gnt_idx_o stable next cycle; at most one ready_o bit set.
// STRUCTURE
//   - Package floo_pkg: add arb_state_e {ArbIdle, ArbLocked}. No other new typedefs; payload is a flat DataWidth vector.
//   - Sub-module floo_rr_prio_sel: combinational rotate-by-rr_ptr + leading-zero find.
//       - Ports req_i[NumInp], ptr_i, idx_o, any_o.
//       - Reused by other floo arbiters.
//   - Top level holds the state FSM, registers and output mux only.
// TESTING
//   1. Reset: rst_i=1 with valid_i=4'b1111 -> valid_o=0, ready_o=0, locked_o=0. Release -> gnt_idx_o=0 in the first cycle.
//   2. Rotation: all sources send 1-flit packets (last=1), ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles, locked_o never 1.
//   3. Wormhole: src1 sends a 3-flit packet and src0 raises valid on flit 2 ->
//        - link carries src1 flits 1..3 contiguously;
//        - src0 is granted next cycle; rr_ptr ends at 1 after the src0 packet.
//   4. Stall stability: src2 valid, ready_i=0 for 5 cycles, src0 raises valid in cycle 2 ->
//        - gnt_idx_o stays 2 and data_o is unchanged;
//        - src0 is served after src2's last flit.
//   5. Bubble: locked src3 drops valid for 2 cycles mid-packet while src1 is valid -> valid_o=0, ready_o[1]=0, grant resumes on src3.
//   6. Mid-packet reset: src1 has 2 of 4 flits sent, rst_i pulsed one cycle -> locked_o=0, rr_ptr=0, next grant goes to the lowest valid index.

Source files
------------

// File: rtl/floo_pkg.sv
// -----------------------------------------------------------------------------
// floo_pkg
//   Shared types for the floo NoC building blocks.
//   arb_state_e : state of the wormhole arbiter (idle / grant held).
// -----------------------------------------------------------------------------
package floo_pkg;

  typedef enum logic [0:0] {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/floo_wormhole_arbiter_if.sv
// -----------------------------------------------------------------------------
// floo_wormhole_arbiter_if
//   Bundles the NumInp source flit streams and the shared link flit stream
//   of the wormhole arbiter.
//   Source side : valid_i, ready_o, data_i, last_i  (one lane per source)
//   Link side   : valid_o, ready_i, data_o, last_o
//   Status      : gnt_idx_o (selected source), locked_o (grant held)
//   Modports    : slave  - the arbiter itself
//                 master - the environment driving sources and the link sink
// -----------------------------------------------------------------------------
interface floo_wormhole_arbiter_if #(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdxWidth  = $clog2(NumInp)
);

  logic [NumInp-1:0]                valid_i;
  logic [NumInp-1:0]                ready_o;
  logic [NumInp-1:0][DataWidth-1:0] data_i;
  logic [NumInp-1:0]                last_i;
  logic                             valid_o;
  logic                             ready_i;
  logic [DataWidth-1:0]             data_o;
  logic                             last_o;
  logic [IdxWidth-1:0]              gnt_idx_o;
  logic                             locked_o;

  modport slave (
    input  valid_i, data_i, last_i, ready_i,
    output ready_o, valid_o, data_o, last_o, gnt_idx_o, locked_o
  );

  modport master (
    output valid_i, data_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, gnt_idx_o, locked_o
  );

endinterface

// File: rtl/floo_rr_prio_sel.sv
// -----------------------------------------------------------------------------
// floo_rr_prio_sel
//   Combinational round-robin priority selector. Scans req_i starting at
//   ptr_i and wrapping modulo NumInp; returns the first requesting index.
//   req_i : request vector
//   ptr_i : highest-priority index this cycle (must be < NumInp)
//   idx_o : winning index (0 when nothing requests)
//   any_o : at least one request present
// -----------------------------------------------------------------------------
module floo_rr_prio_sel #(
  parameter int unsigned NumInp   = 4,
  parameter int unsigned IdxWidth = $clog2(NumInp)
) (
  input  logic [NumInp-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                any_o
);

  // cand[k] is the source index at rotation offset k from ptr_i.
  logic [IdxWidth-1:0] cand [NumInp];
  logic [NumInp-1:0]   cand_req;

  generate
    for (genvar gi = 0; gi < NumInp; gi++) begin : g_cand
      logic [IdxWidth:0] sum;
      // One extra bit so ptr_i + gi never overflows before the wrap test;
      // a single conditional subtract is enough because both terms are < NumInp.
      assign sum         = {1'b0, ptr_i} + (IdxWidth+1)'(gi);
      assign cand[gi]    = (sum >= (IdxWidth+1)'(NumInp))
                           ? IdxWidth'(sum - (IdxWidth+1)'(NumInp))
                           : sum[IdxWidth-1:0];
      assign cand_req[gi] = req_i[cand[gi]];
    end
  endgenerate

  // Walk from the largest offset down so the smallest requesting offset wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = NumInp - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        idx_o = cand[i];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floo_wormhole_arbiter.sv
// -----------------------------------------------------------------------------
// floo_wormhole_arbiter
//   Round-robin, packet-atomic arbiter sharing one NoC link among NumInp
//   flit sources. A granted source owns the link until its last flit
//   handshakes. The flit path is combinational (zero latency).
//   clk_i : clock, all state on the rising edge
//   rst_i : synchronous active-high reset; also forces all outputs to 0
//   bus   : floo_wormhole_arbiter_if.slave (sources, link, grant status)
// -----------------------------------------------------------------------------
module floo_wormhole_arbiter
  import floo_pkg::*;
#(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdxWidth  = $clog2(NumInp)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  floo_wormhole_arbiter_if.slave bus
);

  arb_state_e          state_reg,    state_next;
  logic [IdxWidth-1:0] rr_ptr_reg,   rr_ptr_next;
  logic [IdxWidth-1:0] lock_idx_reg, lock_idx_next;

  logic [IdxWidth-1:0] prio_idx;
  logic                prio_any;
  logic [IdxWidth-1:0] sel;
  logic [IdxWidth-1:0] sel_inc;
  logic                link_valid;
  logic                link_last;
  logic                handshake;

  floo_rr_prio_sel #(
    .NumInp   (NumInp),
    .IdxWidth (IdxWidth)
  ) u_prio_sel (
    .req_i (bus.valid_i),
    .ptr_i (rr_ptr_reg),
    .idx_o (prio_idx),
    .any_o (prio_any)
  );

  // While locked only the owner is looked at; a bubble from the owner
  // shows up as valid_o=0 rather than letting another source in.
  always_comb begin
    if (state_reg == ArbLocked) begin
      sel        = lock_idx_reg;
      link_valid = bus.valid_i[lock_idx_reg];
    end else begin
      sel        = prio_any ? prio_idx : '0;
      link_valid = prio_any;
    end
  end

  assign link_last = bus.last_i[sel];
  assign handshake = link_valid & bus.ready_i;
  assign sel_inc   = (sel == IdxWidth'(NumInp - 1)) ? '0 : sel + IdxWidth'(1);

  // Locking also on a stalled single-flit packet keeps the offered flit
  // stable even if a higher-priority source raises valid meanwhile.
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    lock_idx_next = lock_idx_reg;
    case (state_reg)
      ArbIdle: begin
        if (handshake && link_last) begin
          rr_ptr_next = sel_inc;
        end else if (link_valid) begin
          state_next    = ArbLocked;
          lock_idx_next = sel;
        end
      end
      ArbLocked: begin
        if (handshake && link_last) begin
          state_next  = ArbIdle;
          rr_ptr_next = sel_inc;
        end
      end
      default: state_next = ArbIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ArbIdle;
      rr_ptr_reg   <= '0;
      lock_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

  // Output mux; everything is held at zero while reset is asserted.
  always_comb begin
    bus.valid_o   = 1'b0;
    bus.data_o    = '0;
    bus.last_o    = 1'b0;
    bus.ready_o   = '0;
    bus.gnt_idx_o = '0;
    bus.locked_o  = 1'b0;
    if (!rst_i) begin
      bus.valid_o      = link_valid;
      bus.data_o       = bus.data_i[sel];
      bus.last_o       = link_last;
      bus.ready_o[sel] = bus.ready_i;
      bus.gnt_idx_o    = sel;
      bus.locked_o     = (state_reg == ArbLocked);
    end
  end

  ast_stall_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.valid_o && !bus.ready_i) |=>
      (bus.valid_o && $stable(bus.data_o) && $stable(bus.gnt_idx_o)));

  ast_ready_onehot : assert property (@(posedge clk_i) $onehot0(bus.ready_o));

endmodule
